lbist_controller: RTL



---
 rtl/lbist_pkg.sv | 28 ++
 rtl/lbist_watchdog.sv | 36 +++
 rtl/lbist_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lbist_pkg.sv
// lbist_pkg: FSM state type and a packed-vector slicing helper shared by the LBIST controller.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISR_CFG,
    LFSR_SEED,
    WAIT_SIG,
    DONE
  } lbist_state_e;

  localparam int unsigned VEC_MAX_BITS   = 1024;
  localparam int unsigned SLICE_MAX_BITS = 64;

  // Returns slice idx of a packed vector whose slices are width bits each.
  function automatic logic [SLICE_MAX_BITS-1:0] get_slice(
    input logic [VEC_MAX_BITS-1:0] vec,
    input int unsigned             idx,
    input int unsigned             width
  );
    logic [VEC_MAX_BITS-1:0]   shifted;
    logic [SLICE_MAX_BITS-1:0] mask;
    shifted = vec >> (idx * width);
    mask    = {SLICE_MAX_BITS{1'b1}} >> (SLICE_MAX_BITS - width);
    return shifted[SLICE_MAX_BITS-1:0] & mask;
  endfunction

endpackage

// File: rtl/lbist_watchdog.sv
// lbist_watchdog: loadable up-counter that flags when it reaches LIMIT-1.
// Only instantiated when LBIST_TIMEOUT_EN is defined.
module lbist_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == CNT_W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lbist_controller.sv
// lbist_controller: runs one logic-BIST session over NUM_SEEDS seed/golden pairs.
// Define LBIST_TIMEOUT_EN to add a WAIT_SIG watchdog and the ctrl_resp_timeout output.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int unsigned                          NUM_SEEDS           = 4,
  parameter int unsigned                          SEED_BITS           = 32,
  parameter int unsigned                          SIGNATURE_BITS      = 32,
  parameter int unsigned                          MAX_OUTPUTS_TO_HASH = 32,
  parameter int unsigned                          LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter logic [NUM_SEEDS*SEED_BITS-1:0]       SEEDS               = '0,
  parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0]  GOLDEN_SIGNATURES   = '0,
  parameter int unsigned                          TIMEOUT_CYCLES      = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_req_val,
  output logic                      ctrl_req_rdy,
  output logic                      ctrl_resp_val,
  output logic [NUM_SEEDS-1:0]      ctrl_resp_msg,
  input  logic                      ctrl_resp_rdy,
  output logic                      misr_req_val,
  output logic [LBIST_MSG_BITS:0]   misr_req_msg,
  input  logic                      misr_req_rdy,
  input  logic                      misr_resp_val,
  input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
  output logic                      misr_resp_rdy,
  output logic                      lfsr_req_val,
  output logic [SEED_BITS-1:0]      lfsr_req_msg,
  input  logic                      lfsr_req_rdy
`ifdef LBIST_TIMEOUT_EN
  ,
  output logic                      ctrl_resp_timeout
`endif
);

  localparam int unsigned IDX_W = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
  localparam int unsigned MSG_W = LBIST_MSG_BITS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SEEDS - 1);
  localparam logic [MSG_W-1:0] HASH_COUNT = MSG_W'(MAX_OUTPUTS_TO_HASH);

  lbist_state_e              state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_SEEDS-1:0]      result_q, result_d;
  logic [SIGNATURE_BITS-1:0] golden;
  logic                      wd_expired;

  logic                      ctrl_req_rdy_q, ctrl_req_rdy_d;
  logic                      ctrl_resp_val_q, ctrl_resp_val_d;
  logic [NUM_SEEDS-1:0]      ctrl_resp_msg_q, ctrl_resp_msg_d;
  logic                      misr_req_val_q, misr_req_val_d;
  logic [MSG_W-1:0]          misr_req_msg_q, misr_req_msg_d;
  logic                      misr_resp_rdy_q, misr_resp_rdy_d;
  logic                      lfsr_req_val_q, lfsr_req_val_d;
  logic [SEED_BITS-1:0]      lfsr_req_msg_q, lfsr_req_msg_d;

`ifdef LBIST_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_load;

  // Counter restarts on each entry to WAIT_SIG so every seed gets a full window.
  assign wd_load = (state_q != WAIT_SIG) && (state_d == WAIT_SIG);

  lbist_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .en     (state_q == WAIT_SIG),
    .expired(wd_expired)
  );

  assign ctrl_resp_timeout = timeout_q;
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    golden   = SIGNATURE_BITS'(get_slice(VEC_MAX_BITS'(GOLDEN_SIGNATURES), 32'(idx_q), SIGNATURE_BITS));
`ifdef LBIST_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctrl_req_val) begin
          idx_d    = '0;
          result_d = '0;
`ifdef LBIST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = MISR_CFG;
        end
      end
      MISR_CFG:  if (misr_req_rdy) state_d = LFSR_SEED;
      LFSR_SEED: if (lfsr_req_rdy) state_d = WAIT_SIG;
      WAIT_SIG: begin
        if (misr_resp_val) begin
          result_d[idx_q] = (misr_resp_msg == golden);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = MISR_CFG;
          end
        end else if (wd_expired) begin
          result_d[idx_q] = 1'b0;
`ifdef LBIST_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
          state_d = DONE;
        end
      end
      DONE:    if (ctrl_resp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each val/msg is glitch-free.
    ctrl_req_rdy_d  = (state_d == IDLE);
    ctrl_resp_val_d = (state_d == DONE);
    ctrl_resp_msg_d = (state_d == DONE) ? result_d : '0;
    misr_req_val_d  = (state_d == MISR_CFG);
    misr_req_msg_d  = (state_d == MISR_CFG) ? HASH_COUNT : '0;
    misr_resp_rdy_d = (state_d == WAIT_SIG);
    lfsr_req_val_d  = (state_d == LFSR_SEED);
    lfsr_req_msg_d  = (state_d == LFSR_SEED)
                    ? SEED_BITS'(get_slice(VEC_MAX_BITS'(SEEDS), 32'(idx_d), SEED_BITS))
                    : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      result_q        <= '0;
      ctrl_req_rdy_q  <= 1'b1;
      ctrl_resp_val_q <= 1'b0;
      ctrl_resp_msg_q <= '0;
      misr_req_val_q  <= 1'b0;
      misr_req_msg_q  <= '0;
      misr_resp_rdy_q <= 1'b0;
      lfsr_req_val_q  <= 1'b0;
      lfsr_req_msg_q  <= '0;
`ifdef LBIST_TIMEOUT_EN
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      result_q        <= result_d;
      ctrl_req_rdy_q  <= ctrl_req_rdy_d;
      ctrl_resp_val_q <= ctrl_resp_val_d;
      ctrl_resp_msg_q <= ctrl_resp_msg_d;
      misr_req_val_q  <= misr_req_val_d;
      misr_req_msg_q  <= misr_req_msg_d;
      misr_resp_rdy_q <= misr_resp_rdy_d;
      lfsr_req_val_q  <= lfsr_req_val_d;
      lfsr_req_msg_q  <= lfsr_req_msg_d;
`ifdef LBIST_TIMEOUT_EN
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign ctrl_req_rdy  = ctrl_req_rdy_q;
  assign ctrl_resp_val = ctrl_resp_val_q;
  assign ctrl_resp_msg = ctrl_resp_msg_q;
  assign misr_req_val  = misr_req_val_q;
  assign misr_req_msg  = misr_req_msg_q;
  assign misr_resp_rdy = misr_resp_rdy_q;
  assign lfsr_req_val  = lfsr_req_val_q;
  assign lfsr_req_msg  = lfsr_req_msg_q;

endmodule
